// File: rtl/debounce_filter_multi.sv
// debounce_filter_multi: per-channel synchroniser, debouncer, edge pulses and long-press detect
module debounce_filter_multi #(
    parameter int NUM_CH         = 4,
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int HOLD_LIMIT     = 25000000,
    parameter bit INIT_STATE     = 1'b0
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic [NUM_CH-1:0] i_Bouncy,
    output logic [NUM_CH-1:0] o_Debounced,
    output logic [NUM_CH-1:0] o_Rise,
    output logic [NUM_CH-1:0] o_Fall,
    output logic [NUM_CH-1:0] o_Held
);
    localparam int DW = $clog2(DEBOUNCE_LIMIT + 1);
    localparam int HW = $clog2(HOLD_LIMIT + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_LIMIT - 1);
    localparam logic [HW-1:0] H_MAX = HW'(HOLD_LIMIT);
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic meta, sync, state, rise, fall;
        logic [DW-1:0] cnt;
        logic [HW-1:0] hold;
        logic flip;
        assign flip = (sync != state) && (cnt == D_LAST);
        always_ff @(posedge i_Clk) begin
            if (i_Reset) begin
                meta  <= INIT_STATE;
                sync  <= INIT_STATE;
                state <= INIT_STATE;
                cnt   <= '0;
                hold  <= '0;
                rise  <= 1'b0;
                fall  <= 1'b0;
            end else begin
                meta  <= i_Bouncy[c];
                sync  <= meta;
                cnt   <= (sync == state || flip) ? '0 : cnt + 1'b1;
                state <= flip ? sync : state;
                rise  <= flip & sync;
                fall  <= flip & ~sync;
                // a 1->0 flip only happens while state is 1, so flip here means release
                hold  <= (!state || flip) ? '0 : (hold == H_MAX ? hold : hold + 1'b1);
            end
        end
        assign o_Debounced[c] = state;
        assign o_Rise[c]      = rise;
        assign o_Fall[c]      = fall;
        assign o_Held[c]      = (hold == H_MAX);
    end
endmodule

// File: tb/tb_debounce_filter_multi.sv
// tb_debounce_filter_multi: directed checks of debounce, edge pulses, hold and reset behaviour
module tb_debounce_filter_multi;
    logic clk = 1'b0;
    logic rst;
    logic [3:0] b, deb, rise, fall, held;
    logic [3:0] b1, deb1, rise1, fall1, held1;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    debounce_filter_multi #(.NUM_CH(4), .DEBOUNCE_LIMIT(8), .HOLD_LIMIT(20), .INIT_STATE(1'b0)) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Bouncy(b),
        .o_Debounced(deb), .o_Rise(rise), .o_Fall(fall), .o_Held(held)
    );
    debounce_filter_multi #(.NUM_CH(4), .DEBOUNCE_LIMIT(8), .HOLD_LIMIT(20), .INIT_STATE(1'b1)) dut1 (
        .i_Clk(clk), .i_Reset(rst), .i_Bouncy(b1),
        .o_Debounced(deb1), .o_Rise(rise1), .o_Fall(fall1), .o_Held(held1)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    initial begin
        logic [3:0] seen_r, seen_f, seen_h, seen_d;
        int nr, nf;
        rst = 1'b1;
        b = 4'h0;
        b1 = 4'hF;
        tick(2);
        rst = 1'b0;
        check("rst_deb", deb, 4'h0);
        check("rst_pulses", {rise, fall, held}, 12'h000);
        check("rst_deb_init1", deb1, 4'hF);
        check("rst_pulses_init1", {rise1, fall1, held1}, 12'h000);
        // INIT_STATE=1: hold counts from release, no rise pulse
        seen_r = 4'h0;
        for (int i = 0; i < 19; i++) begin
            tick();
            seen_r |= rise1;
        end
        check("init1_no_rise", seen_r, 4'h0);
        check("init1_held_early", held1, 4'h0);
        tick();
        check("init1_held", held1, 4'hF);
        check("init1_deb", deb1, 4'hF);
        // clean press ch0
        b[0] = 1'b1;
        tick(9);
        check("t1_deb_early", deb, 4'h0);
        tick();
        check("t1_deb", deb, 4'h1);
        check("t1_rise", rise, 4'h1);
        check("t1_fall", fall, 4'h0);
        tick();
        check("t1_rise_gone", rise, 4'h0);
        check("t1_deb_stay", deb, 4'h1);
        b[0] = 1'b0;
        tick(9);
        check("t1_rel_early", deb, 4'h1);
        tick();
        check("t1_rel_deb", deb, 4'h0);
        check("t1_rel_fall", fall, 4'h1);
        tick(3);
        // bounce on ch1
        seen_d = 4'h0;
        seen_r = 4'h0;
        for (int i = 0; i < 30; i++) begin
            b[1] = (i < 5 || (i >= 6 && i < 11)) ? 1'b1 : 1'b0;
            tick();
            seen_d |= deb;
            seen_r |= rise;
        end
        check("t2_deb", seen_d, 4'h0);
        check("t2_rise", seen_r, 4'h0);
        // long press ch2
        b[2] = 1'b1;
        tick(10);
        check("t3_rise", rise, 4'h4);
        check("t3_held0", held, 4'h0);
        tick(19);
        check("t3_held_early", held, 4'h0);
        tick();
        check("t3_held", held, 4'h4);
        tick(20);
        check("t3_held_stay", held, 4'h4);
        b[2] = 1'b0;
        tick(9);
        check("t3_rel_early", {deb, held}, 8'h44);
        tick();
        check("t3_rel_deb_held", {deb, held}, 8'h00);
        check("t3_rel_fall", fall, 4'h4);
        tick();
        check("t3_fall_gone", fall, 4'h0);
        // short press ch3
        nr = 0;
        nf = 0;
        seen_h = 4'h0;
        b[3] = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (i == 10) b[3] = 1'b0;
            tick();
            nr += int'(rise[3]);
            nf += int'(fall[3]);
            seen_h |= held;
        end
        check("t4_rises", nr, 1);
        check("t4_falls", nf, 1);
        check("t4_no_held", seen_h, 4'h0);
        check("t4_deb", deb, 4'h0);
        // reset mid-operation: ch2 held, ch0 count at 5
        b[2] = 1'b1;
        tick(23);
        b[0] = 1'b1;
        tick(7);
        check("t5_pre", {deb, held}, 8'h44);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_deb", deb, 4'h0);
        check("t5_rst_pulses", {rise, fall, held}, 12'h000);
        seen_f = 4'h0;
        seen_r = 4'h0;
        for (int i = 0; i < 9; i++) begin
            tick();
            seen_f |= fall;
            seen_r |= rise;
        end
        check("t5_no_fall", seen_f, 4'h0);
        check("t5_no_rise", seen_r, 4'h0);
        check("t5_deb_early", deb, 4'h0);
        tick();
        check("t5_deb", deb, 4'h5);
        check("t5_rise", rise, 4'h5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
